rle_encoder: RTL and testbench

Run-length encoder placed between the sampler and the sample FIFO.
- It consumes the sampler's valid-qualified sample stream.
- It produces a compressed word stream for the FIFO's data/enable inputs.
- With compression disabled it is a registered pass-through.
- It lets a long idle capture fit in the FIFO. The controller drives enable, flush and clear.

---
 rtl/rle_encoder_if.sv | 13 +
 rtl/rle_encoder.sv | 169 ++++++++++++++++
 tb/tb_rle_encoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_encoder_if.sv
// Sample stream into the run-length encoder and encoded word stream out to the sample FIFO.
// Handshake: each *_valid is a one-cycle strobe qualifying *_data in that cycle; there is no ready, neither side can stall.
interface rle_encoder_if #(
  parameter int SAMPLE_WIDTH = 8
);
  logic                    in_valid;
  logic [SAMPLE_WIDTH-1:0] in_data;
  logic                    out_valid;
  logic [SAMPLE_WIDTH-1:0] out_data;

  modport master (output in_valid, output in_data, input out_valid, input out_data);
  modport slave  (input in_valid, input in_data, output out_valid, output out_data);
endinterface

// File: rtl/rle_encoder.sv
// Run-length encoder between the sampler and the sample FIFO; registered pass-through when enable=0.
// Sample words carry MSB=0, count words MSB=1; a small queue absorbs the two-word bursts.
module rle_encoder #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    clear,
  rle_encoder_if.slave            bus,
  output logic                    busy,
  output logic                    overflow,
  output logic                    dbg_state,
  output logic [SAMPLE_WIDTH-2:0] dbg_count
);

  localparam int N  = SAMPLE_WIDTH;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [N-2:0] MAX_RUN = '1;
  localparam logic [PW:0]  DEPTH_V = (PW+1)'(QUEUE_DEPTH);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [N-2:0]   last_q, last_d;
  logic [N-2:0]   count_q, count_d;
  logic           mode_q, mode_d;
  logic [N-2:0]   sample;
  logic           push_a, push_b;
  logic [N-1:0]   word_a, word_b;

  logic [N-1:0]   mem [QUEUE_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    q_count, q_count_d, occ0, occ1;
  logic           pop, acc_a, acc_b, drop;
  logic           out_valid_q, overflow_q;
  logic [N-1:0]   out_data_q;

  // Next-state and push generation; a same-cycle flush acts on the post-sample state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    count_d = count_q;
    push_a  = 1'b0;
    push_b  = 1'b0;
    word_a  = '0;
    word_b  = '0;
    sample  = bus.in_data[N-2:0];
    mode_d  = (state_q == IDLE && q_count == '0) ? enable : mode_q;
    if (mode_d) begin
      if (bus.in_valid) begin
        if (state_q == IDLE) begin
          push_a  = 1'b1;
          word_a  = {1'b0, sample};
          last_d  = sample;
          count_d = '0;
          state_d = HOLD;
        end else if (sample == last_q) begin
          if (count_q == MAX_RUN - 1'b1) begin
            push_a  = 1'b1;
            word_a  = {1'b1, MAX_RUN};
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          if (count_q != '0) begin
            push_a = 1'b1;
            word_a = {1'b1, count_q};
            push_b = 1'b1;
            word_b = {1'b0, sample};
          end else begin
            push_a = 1'b1;
            word_a = {1'b0, sample};
          end
          last_d  = sample;
          count_d = '0;
        end
      end
      if (flush && state_d == HOLD) begin
        if (count_d != '0) begin
          if (push_a) begin
            push_b = 1'b1;
            word_b = {1'b1, count_d};
          end else begin
            push_a = 1'b1;
            word_a = {1'b1, count_d};
          end
        end
        count_d = '0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      last_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // The pop frees a slot in the same cycle, so acceptance is judged against post-pop occupancy.
  always_comb begin
    pop       = (q_count != '0);
    occ0      = q_count - {{PW{1'b0}}, pop};
    acc_a     = push_a && (occ0 < DEPTH_V);
    occ1      = occ0 + {{PW{1'b0}}, acc_a};
    acc_b     = push_b && (occ1 < DEPTH_V);
    q_count_d = occ1 + {{PW{1'b0}}, acc_b};
    drop      = (push_a && !acc_a) || (push_b && !acc_b);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (acc_a) mem[wr_ptr] <= word_a;
      if (acc_b) mem[wr_ptr + 1'b1] <= word_b;
      wr_ptr  <= wr_ptr + PW'(acc_a) + PW'(acc_b);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      q_count <= q_count_d;
      if (drop) overflow_q <= 1'b1;
      if (!mode_d) begin
        out_valid_q <= bus.in_valid;
        if (bus.in_valid) out_data_q <= bus.in_data;
      end else begin
        out_valid_q <= pop;
        if (pop) out_data_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign overflow      = overflow_q;
  assign busy          = (q_count != '0) || (state_q == HOLD);
  assign dbg_state     = state_q;
  assign dbg_count     = count_q;

endmodule

// File: tb/tb_rle_encoder.sv
// Bench for rle_encoder: directed scenarios plus randomized streams checked against a run-segmentation model.
module tb_rle_encoder;
  localparam int SW = 8;
  localparam int QD = 4;
  localparam int MAX_RUN = 2**(SW-1) - 1;

  typedef struct packed {logic v; logic [SW-1:0] d; logic f;} tok_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic clear = 1'b0;
  logic busy, overflow, dbg_state;
  logic [SW-2:0] dbg_count;

  rle_encoder_if #(.SAMPLE_WIDTH(SW)) bus ();

  rle_encoder #(.SAMPLE_WIDTH(SW), .QUEUE_DEPTH(QD)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .flush(flush), .clear(clear),
    .bus(bus), .busy(busy), .overflow(overflow), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // clock/reset block
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] got_q[$];
  int got_cyc[$];
  int checks = 0;
  int errors = 0;
  bit busy_seen, ovf_seen;

  always @(negedge clock) begin
    if (bus.out_valid === 1'b1) begin
      got_q.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    if (overflow !== 1'b0) ovf_seen = 1'b1;
  end

  // driver tasks
  task automatic drive(input logic v, input logic [SW-1:0] d, input logic f);
    @(posedge clock);
    #1;
    bus.in_valid = v;
    bus.in_data  = d;
    flush        = f;
  endtask

  task automatic drive_tokens(input tok_t t[$]);
    foreach (t[i]) drive(t[i].v, t[i].d, t[i].f);
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (busy === 1'b0 && bus.out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s drain: still busy after 400 cycles, busy=%b required 0", name, busy);
    end
  endtask

  task automatic start_capture();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    busy_seen = 1'b0;
    ovf_seen  = 1'b0;
  endtask

  // reference model: split the stream at flushes, group equal masked samples into runs,
  // and emit each run as one sample word followed by its repeat count split into MAX_RUN chunks
  function automatic void close_run(input logic [SW-2:0] v, input int len);
    int r = len - 1;
    exp_q.push_back({1'b0, v});
    for (int k = 0; k < r / MAX_RUN; k++) exp_q.push_back({1'b1, (SW-1)'(MAX_RUN)});
    if (r % MAX_RUN != 0) exp_q.push_back({1'b1, (SW-1)'(r % MAX_RUN)});
  endfunction

  function automatic void model_rle(input tok_t t[$]);
    bit open = 1'b0;
    logic [SW-2:0] rv = '0;
    int rl = 0;
    foreach (t[i]) begin
      if (t[i].v) begin
        if (open && t[i].d[SW-2:0] == rv) rl++;
        else begin
          if (open) close_run(rv, rl);
          open = 1'b1;
          rv = t[i].d[SW-2:0];
          rl = 1;
        end
      end
      if (t[i].f && open) begin
        close_run(rv, rl);
        open = 1'b0;
      end
    end
  endfunction

  function automatic void model_pass(input tok_t t[$]);
    foreach (t[i]) if (t[i].v) exp_q.push_back(t[i].d);
  endfunction

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: valid=%b data=%h busy=%b ovf=%b required 0 0 0 0",
               bus.out_valid, bus.out_data, busy, overflow);
    end
    checks++;
    if (dbg_state !== 1'b0 || dbg_count !== '0) begin
      errors++;
      $display("FAIL reset state: state=%b count=%0d required 0 0", dbg_state, dbg_count);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_passthrough();
    int c0;
    enable = 1'b0;
    start_capture();
    exp_q = '{8'h81, 8'h81, 8'h3C};
    drive(1'b1, 8'h81, 1'b0);
    c0 = cyc;
    drive(1'b1, 8'h81, 1'b0);
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, '0, 1'b0);
    drain("passthrough");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL passthrough count: got %0d words required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_cyc[i] != c0 + 1 + i) begin
        errors++;
        $display("FAIL passthrough word%0d: got %h at cycle %0d required %h at cycle %0d",
                 i, got_q[i], got_cyc[i], exp_q[i], c0 + 1 + i);
      end
    end
    checks++;
    if (busy_seen) begin
      errors++;
      $display("FAIL passthrough busy: busy seen 1 required 0 throughout");
    end
  endtask

  task automatic test_rle_basic();
    tok_t t[$];
    enable = 1'b1;
    start_capture();
    t = '{'{1'b1, 8'h05, 1'b0}, '{1'b1, 8'h05, 1'b0}, '{1'b1, 8'h05, 1'b0},
          '{1'b1, 8'h09, 1'b0}, '{1'b0, 8'h00, 1'b1}};
    exp_q = '{8'h05, 8'h82, 8'h09};
    drive_tokens(t);
    drain("rle_basic");
    checks++;
    if (got_q.size() != exp_q.size() || !busy_seen) begin
      errors++;
      $display("FAIL rle_basic count: got %0d words busy_seen=%b required %0d words busy_seen=1",
               got_q.size(), busy_seen, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rle_basic word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    tok_t t[$];
    start_capture();
    for (int i = 0; i < 130; i++) t.push_back('{1'b1, 8'h03, 1'b0});
    t.push_back('{1'b0, 8'h00, 1'b1});
    exp_q = '{8'h03, 8'hFF, 8'h82};
    drive_tokens(t);
    drain("saturation");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL saturation count: got %0d words required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL saturation word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (dbg_state !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL saturation idle: state=%b busy=%b required 0 0", dbg_state, busy);
    end
  endtask

  task automatic test_msb_mask();
    tok_t t[$];
    start_capture();
    t = '{'{1'b1, 8'h8A, 1'b0}, '{1'b1, 8'h0A, 1'b0}, '{1'b0, 8'h00, 1'b1}};
    exp_q = '{8'h0A, 8'h81};
    drive_tokens(t);
    drain("msb_mask");
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL msb_mask count: got %0d words required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL msb_mask word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    tok_t t[$];
    logic [SW-1:0] v;
    start_capture();
    for (int k = 1; k <= 7; k++) begin
      v = SW'(k * 8'h11);
      t.push_back('{1'b1, v, 1'b0});
      t.push_back('{1'b1, v, 1'b0});
      exp_q.push_back(v);
      exp_q.push_back(8'h81);
    end
    t.push_back('{1'b0, 8'h00, 1'b1});
    drive_tokens(t);
    drain("back_to_back");
    checks++;
    if (got_q.size() != exp_q.size() || ovf_seen) begin
      errors++;
      $display("FAIL back_to_back count: got %0d words ovf_seen=%b required %0d words ovf_seen=0",
               got_q.size(), ovf_seen, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL back_to_back word%0d: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort_midrun(input bit use_reset);
    string name = use_reset ? "reset_midrun" : "clear_midrun";
    start_capture();
    for (int i = 0; i < 41; i++) drive(1'b1, 8'h05, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clock);
    checks++;
    if (dbg_count !== 7'd40 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL %s open run: count=%0d state=%b required 40 1", name, dbg_count, dbg_state);
    end
    if (use_reset) begin
      #2 reset_n = 1'b0;
      #2;
    end else begin
      @(posedge clock);
      #1 clear = 1'b1;
      @(posedge clock);
      #1 clear = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 ||
        dbg_count !== '0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL %s state: valid=%b busy=%b ovf=%b count=%0d state=%b required all 0",
               name, bus.out_valid, busy, overflow, dbg_count, dbg_state);
    end
    if (use_reset) begin
      @(posedge clock);
      #1 reset_n = 1'b1;
    end
    start_capture();
    exp_q = '{8'h05};
    drive(1'b1, 8'h05, 1'b0);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    drain(name);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL %s restart: got %0d words first %h required 1 word %h",
               name, got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, exp_q[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      tok_t t[$];
      logic [SW-1:0] v;
      int len;
      bit rle = ($urandom_range(0, 3) != 0);
      enable = rle;
      start_capture();
      for (int r = 0; r < $urandom_range(4, 20); r++) begin
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(100, 260) : $urandom_range(1, 6);
        v = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 3))};
        for (int s = 0; s < len; s++) begin
          v[SW-1] = 1'($urandom_range(0, 1));
          t.push_back('{1'b1, v, 1'($urandom_range(0, 15) == 0)});
          if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) t.push_back('{1'b0, 8'h00, 1'b0});
        end
      end
      t.push_back('{1'b0, 8'h00, 1'b1});
      if (rle) model_rle(t);
      else model_pass(t);
      drive_tokens(t);
      drain("random");
      checks++;
      if (got_q.size() != exp_q.size() || ovf_seen) begin
        errors++;
        $display("FAIL random%0d count: mode=%0d got %0d words ovf_seen=%b required %0d words ovf_seen=0",
                 it, rle, got_q.size(), ovf_seen, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random%0d word%0d: got %h required %h", it, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_rle_basic();
    test_saturation();
    test_msb_mask();
    test_back_to_back();
    test_abort_midrun(1'b0);
    test_abort_midrun(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
